uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, which sets the number of flops in the rx_i synchronizer (minimum 2).
REQ-002 The block SHALL provide parameter OVERSAMPLE, default 16, which sets the baud ticks per bit period (even, at least 8).
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 baud_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate, produced by the divisor block.
REQ-006 rx_i  input  1  asynchronous serial line; idle level is 1.
REQ-007 wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 pen  input  1  parity enable.
REQ-009 eps  input  1  even parity select (1=even, 0=odd).
REQ-010 stick  input  1  stick parity: the expected parity bit is ~eps when pen=1.
REQ-011 rx_data  output  8  received word, LSB-aligned, unused upper bits 0.
REQ-012 rx_valid  output  1  one-cycle pulse; rx_data and the status bits are valid in that cycle (feeds RX FIFO push).
REQ-013 parity_err  output  1  parity mismatch for the current word; qualified by rx_valid.
REQ-014 framing_err  output  1  stop bit sampled as 0; qualified by rx_valid.
REQ-015 break_det  output  1  break condition; qualified by rx_valid.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 rx_i SHALL pass through SYNC_STAGES flops reset to 1; all sampling SHALL use the synchronized value rx_s.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BRK_WAIT; a tick counter (log2 OVERSAMPLE bits) and a bit counter (3 bits) SHALL advance only on baud_tick.
REQ-019 IDLE: if rx_s=0 on a baud_tick, the FSM SHALL go to START with tick counter cleared; otherwise it SHALL stay in IDLE.
REQ-020 START: on the OVERSAMPLE/2-th tick (mid-bit), if rx_s=1 the FSM SHALL treat it as a false start and return to IDLE with no rx_valid; else it SHALL go to DATA with tick counter cleared.
REQ-021 DATA: every OVERSAMPLE ticks, rx_s SHALL be sampled into the shift register LSB-first; after 5+wls bits the FSM SHALL go to PARITY if pen=1, else to STOP.
REQ-022 PARITY: the bit SHALL be sampled at mid-bit; expected value = stick ? ~eps : (XOR of data bits) XOR eps XOR 1 for odd/even per 16550 semantics; a mismatch SHALL set the parity flag.
REQ-023 STOP: the bit SHALL be sampled at mid-bit; only one stop bit SHALL be checked regardless of LCR stop-bit setting; a 0 sample SHALL set framing_err.
REQ-024 On the cycle after the stop-bit sample tick, rx_valid SHALL pulse for exactly one cycle with rx_data, parity_err, framing_err and break_det held stable in that cycle.
REQ-025 break_det SHALL be 1 when all data bits, the parity bit (if enabled) and the stop bit were sampled 0; framing_err SHALL also be 1 in that case.
REQ-026 After a word with framing_err=1, the FSM SHALL enter BRK_WAIT and SHALL NOT arm a new start until rx_s=1 is seen on a baud_tick; otherwise it SHALL return to IDLE.
REQ-027 Configuration inputs (wls, pen, eps, stick) SHALL be latched on the IDLE->START transition; changes mid-frame SHALL NOT affect the frame in progress.
REQ-028 Cycles without baud_tick SHALL freeze all counters and the state.
REQ-029 Back-to-back frames SHALL be accepted with no idle gap: a start edge seen on the first tick after STOP SHALL be detected.

Reset
REQ-030 On rst=1, regardless of state: the FSM SHALL go to IDLE; the synchronizer SHALL be set to 1; counters and the shift register SHALL be cleared; rx_data=0, rx_valid=0, parity_err=0, framing_err=0, break_det=0, busy=0.
REQ-031 A reset mid-frame SHALL discard the partial word and produce no rx_valid.

Verification
REQ-032 8N1 (wls=11, pen=0): send 0xA5, stop=1 -> one rx_valid, rx_data=0xA5, all error flags 0.
REQ-033 7E1 (wls=10, pen=1, eps=1): send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-034 8N1: send 0x3C with stop=0, then hold the line high -> rx_data=0x3C, framing_err=1, break_det=0; the next frame 0x55 is received correctly.
REQ-035 Low glitch of OVERSAMPLE/4 ticks on an idle line -> no rx_valid, busy returns to 0 before the mid-bit point plus one tick.
REQ-036 Line held low for 2 frame times -> exactly one rx_valid, rx_data=0x00, break_det=1, framing_err=1; no further rx_valid until the line returns high and a new start arrives.
REQ-037 5N1 (wls=00): send 0x1F, then assert rst at mid-DATA of the next frame -> first rx_data=0x1F; after reset all outputs=0 and no rx_valid for the aborted frame.

Source files
------------

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core_if
//  Description : Received-word bundle from the UART receive core: the data
//                word, its one-cycle valid strobe and the per-word status.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;

    // Receiver core drives the word and status
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output framing_err,
        output break_det
    );

    // Consumer (RX FIFO / register block) samples them on rx_valid
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  framing_err,
        input  break_det
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 16550-style UART receiver. Oversampled start detection,
//                mid-bit sampling of 5..8 data bits, optional parity, a
//                single checked stop bit, and break / framing detection.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       baud_tick,
    input  wire logic       rx_i,
    input  wire logic [1:0] wls,
    input  wire logic       pen,
    input  wire logic       eps,
    input  wire logic       stick,
    output logic            busy,
    uart_rx_core_if.master  rx_if
);

    localparam int             c_CW        = $clog2(OVERSAMPLE);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(OVERSAMPLE - 1);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic [c_CW-1:0]        r_tick_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [1:0]             r_wls;
    logic                   r_pen;
    logic                   r_eps;
    logic                   r_stick;
    logic                   r_any_one;
    logic                   r_par_err;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_parity_err;
    logic                   r_framing_err;
    logic                   r_break_det;

    logic                   w_start;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_samp_data;
    logic                   w_samp_par;
    logic                   w_samp_stop;
    logic [2:0]             w_last_bit;
    logic                   w_par_exp;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_last_bit = 3'd4 + {1'b0, r_wls};
    // Stick parity forces ~eps; otherwise even (eps=1) expects XOR of data.
    assign w_par_exp  = r_stick ? ~r_eps : ((^r_shift) ^ r_eps ^ 1'b1);

    assign busy              = (r_state != S_IDLE);
    assign rx_if.rx_data     = r_rx_data;
    assign rx_if.rx_valid    = r_rx_valid;
    assign rx_if.parity_err  = r_parity_err;
    assign rx_if.framing_err = r_framing_err;
    assign rx_if.break_det   = r_break_det;

    // Metastability synchronizer for the asynchronous line, idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath strobes; nothing moves without a baud tick
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_samp_data = 1'b0;
        w_samp_par  = 1'b0;
        w_samp_stop = 1'b0;
        if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_start     = 1'b1;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == c_CNT_HALF) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == c_CNT_FULL) begin
                        w_cnt_clr   = 1'b1;
                        w_samp_data = 1'b1;
                        if (r_bit_cnt == w_last_bit)
                            w_state_nxt = r_pen ? S_PARITY : S_STOP;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_tick_cnt == c_CNT_FULL) begin
                        w_cnt_clr   = 1'b1;
                        w_samp_par  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == c_CNT_FULL) begin
                        w_cnt_clr   = 1'b1;
                        w_samp_stop = 1'b1;
                        w_state_nxt = w_rx_s ? S_IDLE : S_BRK_WAIT;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_BRK_WAIT: begin
                    if (w_rx_s) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Counters, shift register, per-frame config and running error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wls      <= '0;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_stick    <= 1'b0;
            r_any_one  <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_tick_cnt <= '0;
            else if (w_cnt_inc) r_tick_cnt <= r_tick_cnt + 1'b1;

            if (w_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_wls     <= wls;
                r_pen     <= pen;
                r_eps     <= eps;
                r_stick   <= stick;
                r_any_one <= 1'b0;
                r_par_err <= 1'b0;
            end else begin
                if (w_samp_data) begin
                    r_shift[r_bit_cnt] <= w_rx_s;
                    r_bit_cnt          <= r_bit_cnt + 1'b1;
                end
                if (w_samp_par)
                    r_par_err <= (w_rx_s != w_par_exp);
                if ((w_samp_data || w_samp_par || w_samp_stop) && w_rx_s)
                    r_any_one <= 1'b1;
            end
        end
    end

    // Word output: status captured at the stop sample, valid one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_break_det   <= 1'b0;
        end else begin
            r_rx_valid <= w_samp_stop;
            if (w_samp_stop) begin
                r_rx_data     <= r_shift;
                r_parity_err  <= r_par_err;
                r_framing_err <= ~w_rx_s;
                r_break_det   <= ~w_rx_s & ~r_any_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Scoreboard bench for uart_rx_core. Stimulus pushes the
//                expected word; a monitor pops and compares on rx_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int OS       = 16;
    localparam int BIT_CLKS = 2 * OS;   // baud_tick every other clock

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_i = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       stick = 1'b0;
    logic       busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_rx_core_if u_if ();

    uart_rx_core #(.SYNC_STAGES(2), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_i      (rx_i),
        .wls       (wls),
        .pen       (pen),
        .eps       (eps),
        .stick     (stick),
        .busy      (busy),
        .rx_if     (u_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            baud_tick = ~baud_tick;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every rx_valid must match the oldest expected word
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && u_if.rx_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rx_valid", {31'b0, u_if.rx_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                check("rx_word{data,perr,ferr,brk}",
                      {21'b0, u_if.rx_data, u_if.parity_err, u_if.framing_err, u_if.break_det},
                      {21'b0, e});
            end
        end
    end

    task automatic hold(input logic v, input int clks);
        rx_i = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic has_par, input logic par, input logic stop);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) hold(d[i], BIT_CLKS);
        if (has_par) hold(par, BIT_CLKS);
        hold(stop, BIT_CLKS);
        rx_i = 1'b1;
    endtask

    task automatic drained(input string name);
        repeat (4) @(negedge clk);
        check(name, q.size(), 32'd0);
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"},     {24'b0, u_if.rx_data},     32'd0);
        check({tag, "_rx_valid"},    {31'b0, u_if.rx_valid},    32'd0);
        check({tag, "_parity_err"},  {31'b0, u_if.parity_err},  32'd0);
        check({tag, "_framing_err"}, {31'b0, u_if.framing_err}, 32'd0);
        check({tag, "_break_det"},   {31'b0, u_if.break_det},   32'd0);
        check({tag, "_busy"},        {31'b0, busy},             32'd0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // 8N1 0xA5
        wls = 2'b11; pen = 1'b0;
        q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        drained("8N1_A5_drained");

        // 7E1 0x41 (two ones -> even parity bit 0)
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        q.push_back('{8'h41, 1'b1, 1'b0, 1'b0});
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        q.push_back('{8'h41, 1'b0, 1'b0, 1'b0});
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        drained("7E1_drained");

        // 8N1 framing error, then recovery
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        q.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        hold(1'b1, BIT_CLKS);
        q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        drained("framing_drained");

        // Short low glitch: start armed then rejected at mid-bit
        hold(1'b1, BIT_CLKS);
        hold(1'b0, 2 * (OS / 4));
        check("glitch_busy_high", {31'b0, busy}, 32'd1);
        hold(1'b1, 20);
        check("glitch_busy_low", {31'b0, busy}, 32'd0);
        drained("glitch_no_valid");

        // Break: line low for two frame times
        q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
        hold(1'b0, 2 * 10 * BIT_CLKS);
        check("break_wait_busy", {31'b0, busy}, 32'd1);
        check("break_one_valid", q.size(), 32'd0);
        hold(1'b1, BIT_CLKS);
        check("break_release_busy", {31'b0, busy}, 32'd0);
        drained("break_drained");

        // Back-to-back frames, no idle gap
        q.push_back('{8'h0F, 1'b0, 1'b0, 1'b0});
        q.push_back('{8'hF0, 1'b0, 1'b0, 1'b0});
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1);
        drained("b2b_drained");

        // Config changed mid-frame must not affect the frame in progress
        q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
        fork
            send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * BIT_CLKS) @(negedge clk);
                wls = 2'b00; pen = 1'b1;
            end
        join
        drained("cfg_latch_drained");

        // 5N1 0x1F, then reset in the middle of the next frame
        hold(1'b1, BIT_CLKS);
        wls = 2'b00; pen = 1'b0;
        q.push_back('{8'h1F, 1'b0, 1'b0, 1'b0});
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        drained("5N1_drained");
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b0, BIT_CLKS / 2);
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        drained("aborted_no_valid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
